bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one input bit per clock.
- Sits directly upstream of the registered BCD-to-7-segment decoder stage.
- Produces DIGITS packed BCD nibbles; each nibble drives one decoder instance.
- Start/busy/done handshake; output register holds the last result between conversions, so the decoders see stable digits.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_add3.sv | 12 +
 rtl/bin_to_bcd_seq.sv | 110 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary-to-BCD converter and the downstream
// decoder / display stages.
package bcd_pkg;

    localparam int         BCD_W       = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_e;

    // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
    function automatic bit bcd_digits_fit(input int width, input int digits);
        longint pow10;
        longint max_bin;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        max_bin = (longint'(1) << width) - 1;
        return pow10 > max_bin;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] in_nib,
    output logic [3:0] out_nib
);

    assign out_nib = (in_nib >= ADD3_THRESH) ? in_nib + 4'd3 : in_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, with a start/busy/done handshake and a held result register.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; bcd holds the last result
//   ST_SHIFT | correcting and shifting one binary bit per cycle (busy=1)
//   ST_DONE  | bcd freshly loaded, done=1; start here is accepted again
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_TOT = BCD_W * DIGITS;
    localparam int SW      = BCD_TOT + WIDTH;
    localparam int CW      = $clog2(WIDTH + 1);

    generate
        if (!bcd_digits_fit(WIDTH, DIGITS)) begin : g_bad_params
            $error("bin_to_bcd_seq: DIGITS too small to hold 2**WIDTH-1");
        end
    endgenerate

    bcd_state_e          state_q, state_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BCD_TOT-1:0]  bcd_q, bcd_d;

    logic [SW-1:0]       corrected;
    logic [SW-1:0]       shifted;

    // Binary field passes through; each BCD nibble is corrected on its own.
    assign corrected[WIDTH-1:0] = scratch_q[WIDTH-1:0];

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_add3
            bcd_add3 u_add3 (
                .in_nib  (scratch_q[WIDTH + BCD_W*k +: BCD_W]),
                .out_nib (corrected[WIDTH + BCD_W*k +: BCD_W])
            );
        end
    endgenerate

    assign shifted = {corrected[SW-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    scratch_d = {{BCD_TOT{1'b0}}, bin};
                    cnt_d     = CW'(WIDTH);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted[SW-1 -: BCD_TOT];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    scratch_d = {{BCD_TOT{1'b0}}, bin};
                    cnt_d     = CW'(WIDTH);
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed handshake cases plus a
// full sweep and random values against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    logic [11:0] exp_last = 12'h000;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        ref_bcd = 12'((v / 100) % 10) << 8 | 12'((v / 10) % 10) << 4 | 12'(v % 10);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("busy_done_excl", {31'd0, busy & done}, 32'd0);
            if (done) n_done++;
        end
    end

    // Called at the negedge after an accept edge with idx = how many SHIFT
    // observations already elapsed (1 = first). Returns the idx where done is seen.
    task automatic wait_done(input int idx0, output int idx);
        idx = idx0;
        while (!done && idx < 30) begin
            check_eq("busy_in_shift", {31'd0, busy}, 32'd1);
            check_eq("bcd_hold", {20'd0, bcd}, {20'd0, exp_last});
            @(negedge clk);
            idx++;
        end
        if (!done) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic convert(input int v, input string tag);
        int idx;
        @(negedge clk);
        bin   = 8'(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 8'($urandom);
        wait_done(1, idx);
        check_eq({tag, "_lat"}, idx, 9);
        check_eq({tag, "_bcd"}, {20'd0, bcd}, {20'd0, ref_bcd(v)});
        exp_last = ref_bcd(v);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int idx;
        int snap;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_bcd", {20'd0, bcd}, 32'd0);
        rst_n = 1'b1;

        convert(0,   "zero");
        convert(255, "max");
        convert(99,  "b99");
        convert(100, "b100");

        // start during SHIFT is dropped
        @(negedge clk);
        bin = 8'd37; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bin = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, idx);
        check_eq("drop_lat", idx, 9);
        check_eq("drop_bcd", {20'd0, bcd}, 32'h037);
        exp_last = 12'h037;
        @(negedge clk);
        snap = n_done;
        repeat (15) @(negedge clk);
        check_eq("drop_no_second", n_done, snap);

        // start held high, bin changed during the first conversion
        bin = 8'd42; start = 1'b1;
        @(negedge clk);
        bin = 8'd7;
        wait_done(1, idx);
        check_eq("held1_lat", idx, 9);
        check_eq("held1_bcd", {20'd0, bcd}, 32'h042);
        exp_last = 12'h042;
        @(negedge clk);
        wait_done(1, idx);
        check_eq("held2_period", idx, 9);
        check_eq("held2_bcd", {20'd0, bcd}, 32'h007);
        exp_last = 12'h007;
        start = 1'b0;
        @(negedge clk);
        check_eq("held_stop", {31'd0, done | busy}, 32'd0);

        // asynchronous reset in the middle of SHIFT
        convert(123, "pre_rst");
        @(negedge clk);
        bin = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_bcd", {20'd0, bcd}, 32'd0);
        exp_last = 12'h000;
        @(negedge clk);
        rst_n = 1'b1;
        snap = n_done;
        repeat (12) @(negedge clk);
        check_eq("arst_no_done", n_done, snap);
        convert(200, "post_rst");

        // result held through SHIFT until the done cycle
        convert(123, "stab_a");
        convert(45,  "stab_b");

        for (int v = 0; v < 256; v++) convert(v, "sweep");
        for (int i = 0; i < 40; i++) convert(int'($urandom_range(0, 255)), "rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
